// File: rtl/axis_rr_mux.sv
// axis_rr_mux: N-to-1 AXI4-Stream mux with packet-locked arbitration.
// A grant is taken in IDLE, held for a whole packet (until the TLAST beat is
// accepted), then released, so each packet costs one arbitration bubble.
// The master side is a single registered stage that can drain and reload in
// the same cycle, giving one beat per cycle inside a packet.
module axis_rr_mux #(
  parameter int unsigned NUM_S    = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_S*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_S-1:0]          s_axis_tvalid,
  input  logic [NUM_S-1:0]          s_axis_tlast,
  output logic [NUM_S-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  output logic [ID_W-1:0]           m_axis_tid,
  input  logic                      m_axis_tready,
  output logic [NUM_S-1:0]          o_grant,
  output logic [CNT_W-1:0]          o_pkt_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [NUM_S-1:0]    r_grant;
  logic [ID_W-1:0]     r_gid;
  logic [ID_W-1:0]     r_ptr;

  logic                r_m_valid;
  logic                r_m_last;
  logic [DATA_W-1:0]   r_m_data;
  logic [ID_W-1:0]     r_m_id;
  logic [CNT_W-1:0]    r_pkt_cnt;

  logic                w_any_req;
  logic [ID_W-1:0]     w_win_id;
  logic [NUM_S-1:0]    w_win_oh;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic                w_busy;
  logic                w_out_free;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_beat;
  logic                w_eop;

  // Winner search: each requester's distance from the scan origin is
  // (k - origin) mod NUM_S and the smallest distance wins. Origin is the
  // round-robin pointer, or 0 for fixed priority (lowest index wins).
  always_comb begin
    int unsigned w_base;
    int unsigned w_dist;
    int unsigned w_best;
    w_base   = (ARB_MODE == 0) ? 32'(r_ptr) : 32'd0;
    w_dist   = 0;
    w_best   = NUM_S;
    w_win_id = '0;
    for (int unsigned k = 0; k < NUM_S; k++) begin
      w_dist = (k + NUM_S - w_base) % NUM_S;
      if (s_axis_tvalid[k] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_win_id = ID_W'(k);
      end
    end
  end

  // One-hot form of the winner plus the request summary.
  always_comb begin
    w_win_oh  = '0;
    w_any_req = |s_axis_tvalid;
    for (int unsigned k = 0; k < NUM_S; k++) begin
      w_win_oh[k] = w_any_req && (ID_W'(k) == w_win_id);
    end
  end

  assign w_ptr_nxt = (w_win_id == ID_W'(NUM_S - 1)) ? '0 : (w_win_id + 1'b1);

  // Mux the granted slave's beat; the grant is one-hot (or zero).
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = |(s_axis_tvalid & r_grant);
    w_sel_last  = |(s_axis_tlast & r_grant);
    for (int unsigned k = 0; k < NUM_S; k++) begin
      if (r_grant[k]) begin
        w_sel_data = s_axis_tdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_busy     = (r_state == S_BUSY);
  assign w_out_free = !r_m_valid || m_axis_tready;
  assign w_beat     = w_busy && w_sel_valid && w_out_free;
  assign w_eop      = w_beat && w_sel_last;

  // Slave ready: only the granted port, only while the output stage can take a beat.
  always_comb begin
    s_axis_tready = '0;
    if (w_busy && w_out_free) begin
      s_axis_tready = r_grant;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: arbitrate in IDLE, leave BUSY on the accepted TLAST beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_eop)     w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant, granted index and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_grant <= '0;
      r_gid   <= '0;
      r_ptr   <= '0;
    end else if ((r_state == S_IDLE) && w_any_req) begin
      r_grant <= w_win_oh;
      r_gid   <= w_win_id;
      if (ARB_MODE == 0) begin
        r_ptr <= w_ptr_nxt;
      end
    end else if (w_eop) begin
      r_grant <= '0;
    end
  end

  // Output stage: load on an accepted beat (possibly while draining), else clear valid on drain.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      r_m_id    <= '0;
    end else if (w_beat) begin
      r_m_valid <= 1'b1;
      r_m_last  <= w_sel_last;
      r_m_data  <= w_sel_data;
      r_m_id    <= r_gid;
    end else if (r_m_valid && m_axis_tready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Saturating count of packets whose TLAST beat was accepted.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pkt_cnt <= '0;
    end else if (w_eop && (r_pkt_cnt != '1)) begin
      r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

  assign m_axis_tdata  = r_m_data;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tid    = r_m_id;
  assign o_grant       = r_grant;
  assign o_pkt_cnt     = r_pkt_cnt;

endmodule

// File: tb/tb_axis_rr_mux.sv
// Bench for axis_rr_mux: cycle table (single packet, backpressure), then
// round-robin fairness with a 2-bit-counter twin, mid-packet reset, fixed priority.
module tb_axis_rr_mux;

  localparam int NS = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS-1:0]     s_tvalid, s_tlast;
  logic              m_ready;

  logic [NS-1:0]     rr_tready, sat_tready, fp_tready;
  logic [DW-1:0]     rr_mdata, sat_mdata, fp_mdata;
  logic              rr_mvalid, sat_mvalid, fp_mvalid;
  logic              rr_mlast, sat_mlast, fp_mlast;
  logic [1:0]        rr_mtid, sat_mtid, fp_mtid;
  logic [NS-1:0]     rr_grant, sat_grant, fp_grant;
  logic [15:0]       rr_cnt, fp_cnt;
  logic [1:0]        sat_cnt;

  logic [NS*DW-1:0]  fp_tdata;
  logic [NS-1:0]     fp_tvalid, fp_tlast;
  logic              fp_mrdy;

  axis_rr_mux #(.NUM_S(4), .DATA_W(8), .ID_W(2), .ARB_MODE(0), .CNT_W(16)) u_rr (
    .i_clk(clk), .i_rst(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(rr_tready),
    .m_axis_tdata(rr_mdata), .m_axis_tvalid(rr_mvalid), .m_axis_tlast(rr_mlast),
    .m_axis_tid(rr_mtid), .m_axis_tready(m_ready),
    .o_grant(rr_grant), .o_pkt_cnt(rr_cnt));

  axis_rr_mux #(.NUM_S(4), .DATA_W(8), .ID_W(2), .ARB_MODE(0), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(sat_tready),
    .m_axis_tdata(sat_mdata), .m_axis_tvalid(sat_mvalid), .m_axis_tlast(sat_mlast),
    .m_axis_tid(sat_mtid), .m_axis_tready(m_ready),
    .o_grant(sat_grant), .o_pkt_cnt(sat_cnt));

  axis_rr_mux #(.NUM_S(4), .DATA_W(8), .ID_W(2), .ARB_MODE(1), .CNT_W(16)) u_fp (
    .i_clk(clk), .i_rst(rst_n),
    .s_axis_tdata(fp_tdata), .s_axis_tvalid(fp_tvalid), .s_axis_tlast(fp_tlast),
    .s_axis_tready(fp_tready),
    .m_axis_tdata(fp_mdata), .m_axis_tvalid(fp_mvalid), .m_axis_tlast(fp_mlast),
    .m_axis_tid(fp_mtid), .m_axis_tready(fp_mrdy),
    .o_grant(fp_grant), .o_pkt_cnt(fp_cnt));

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] dat;
    logic        mrdy;
    logic        e_mv;
    logic [7:0]  e_dat;
    logic        e_last;
    logic [1:0]  e_tid;
    logic [3:0]  e_grant;
    logic [3:0]  e_trdy;
    int          e_cnt;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int sat_of(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic do_reset();
    s_tvalid  = '0; s_tlast = '0; s_tdata = '0;
    fp_tvalid = '0; fp_tlast = '0; fp_tdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Offer one beat on port p until accepted (bounded), then drop tvalid.
  task automatic push_beat(input int p, input logic [7:0] d, input logic l);
    logic ok;
    s_tvalid = '0; s_tvalid[p] = 1'b1;
    s_tlast  = '0; s_tlast[p]  = l;
    s_tdata  = '0; s_tdata[p*8 +: 8] = d;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rr_tready[p]) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) chk("push_timeout", 32'(ok), 32'd1);
    s_tvalid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    int   beat[4];
    int   exp_tid[5];
    int   npk, ob, nfp;
    logic [3:0] acc;

    rst_n = 1'b0; m_ready = 1'b1; fp_mrdy = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    fp_tvalid = '0; fp_tlast = '0; fp_tdata = '0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_mvalid", 32'(rr_mvalid), 0);
    chk("rst_mlast",  32'(rr_mlast), 0);
    chk("rst_mdata",  32'(rr_mdata), 0);
    chk("rst_tid",    32'(rr_mtid), 0);
    chk("rst_grant",  32'(rr_grant), 0);
    chk("rst_tready", 32'(rr_tready), 0);
    chk("rst_cnt",    32'(rr_cnt), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Cycle table: port 0 packet 56,89 then port 1 packet A1,A2,A3 with 3 stall cycles.
    //            vld      lst      dat            mrdy  mv    dat    last  tid    grant    trdy     cnt
    tbl[0]  = '{4'b0001, 4'b0000, 32'h0000_0056, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'b0001, 4'b0001, 0};
    tbl[1]  = '{4'b0001, 4'b0000, 32'h0000_0056, 1'b1, 1'b1, 8'h56, 1'b0, 2'd0, 4'b0001, 4'b0001, 0};
    tbl[2]  = '{4'b0001, 4'b0001, 32'h0000_0089, 1'b1, 1'b1, 8'h89, 1'b1, 2'd0, 4'b0000, 4'b0000, 1};
    tbl[3]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000, 4'b0000, 1};
    tbl[4]  = '{4'b0010, 4'b0000, 32'h0000_A100, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'b0010, 4'b0010, 1};
    tbl[5]  = '{4'b0010, 4'b0000, 32'h0000_A100, 1'b1, 1'b1, 8'hA1, 1'b0, 2'd1, 4'b0010, 4'b0010, 1};
    tbl[6]  = '{4'b0010, 4'b0000, 32'h0000_A200, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd1, 4'b0010, 4'b0000, 1};
    tbl[7]  = '{4'b0010, 4'b0000, 32'h0000_A200, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd1, 4'b0010, 4'b0000, 1};
    tbl[8]  = '{4'b0010, 4'b0000, 32'h0000_A200, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd1, 4'b0010, 4'b0000, 1};
    tbl[9]  = '{4'b0010, 4'b0000, 32'h0000_A200, 1'b1, 1'b1, 8'hA2, 1'b0, 2'd1, 4'b0010, 4'b0010, 1};
    tbl[10] = '{4'b0010, 4'b0010, 32'h0000_A300, 1'b1, 1'b1, 8'hA3, 1'b1, 2'd1, 4'b0000, 4'b0000, 2};
    tbl[11] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000, 4'b0000, 2};

    for (int i = 0; i < 12; i++) begin
      s_tvalid = tbl[i].vld; s_tlast = tbl[i].lst; s_tdata = tbl[i].dat; m_ready = tbl[i].mrdy;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_mvalid", i), 32'(rr_mvalid), 32'(tbl[i].e_mv));
      chk($sformatf("tbl%0d_grant", i),  32'(rr_grant),  32'(tbl[i].e_grant));
      chk($sformatf("tbl%0d_tready", i), 32'(rr_tready), 32'(tbl[i].e_trdy));
      chk($sformatf("tbl%0d_cnt", i),    32'(rr_cnt),    32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_satcnt", i), 32'(sat_cnt),   32'(sat_of(tbl[i].e_cnt)));
      if (tbl[i].e_mv) begin
        chk($sformatf("tbl%0d_mdata", i), 32'(rr_mdata), 32'(tbl[i].e_dat));
        chk($sformatf("tbl%0d_mlast", i), 32'(rr_mlast), 32'(tbl[i].e_last));
        chk($sformatf("tbl%0d_tid", i),   32'(rr_mtid),  32'(tbl[i].e_tid));
      end
    end

    // Round-robin fairness: all ports offer 2-beat packets, data = 16*k + beat.
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) beat[k] = 0;
    exp_tid = '{0, 1, 2, 3, 0};
    npk = 0; ob = 0;
    for (int cyc = 0; cyc < 80 && npk < 5; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        s_tdata[k*8 +: 8] = 8'(16*k + beat[k]);
        s_tlast[k] = (beat[k] == 1);
      end
      s_tvalid = '1;
      @(negedge clk);
      acc = s_tvalid & rr_tready;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) if (acc[k]) beat[k] = 1 - beat[k];
      if (rr_mvalid) begin
        chk("rr_tid",  32'(rr_mtid),  32'(exp_tid[npk]));
        chk("rr_data", 32'(rr_mdata), 32'(8'(16*exp_tid[npk] + ob)));
        chk("rr_last", 32'(rr_mlast), 32'(ob == 1));
        if (rr_mlast) begin
          npk++;
          chk("rr_cnt",  32'(rr_cnt),  32'(npk));
          chk("sat_cnt", 32'(sat_cnt), 32'(sat_of(npk)));
          ob = 0;
        end else begin
          ob++;
        end
      end
    end
    chk("rr_packets", 32'(npk), 32'd5);
    s_tvalid = '0;

    // Mid-packet asynchronous reset, then a fresh packet from port 2.
    do_reset();
    m_ready = 1'b1;
    push_beat(0, 8'hA0, 1'b1);
    chk("prerst_cnt", 32'(rr_cnt), 32'd1);
    push_beat(2, 8'hC0, 1'b0);
    push_beat(2, 8'hC1, 1'b0);
    chk("prerst_mdata", 32'(rr_mdata), 32'h0000_00C1);
    s_tvalid = 4'b0100; s_tdata = 32'h00C2_0000; s_tlast = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mvalid", 32'(rr_mvalid), 0);
    chk("arst_grant",  32'(rr_grant),  0);
    chk("arst_cnt",    32'(rr_cnt),    0);
    chk("arst_tready", 32'(rr_tready), 0);
    s_tvalid = '0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    s_tvalid = 4'b0100; s_tdata = 32'h00D0_0000; s_tlast = 4'b0100;
    @(posedge clk); #1;
    chk("post_grant", 32'(rr_grant), 32'b0100);
    @(posedge clk); #1;
    s_tvalid = '0;
    chk("post_mvalid", 32'(rr_mvalid), 1);
    chk("post_tid",    32'(rr_mtid),   2);
    chk("post_mdata",  32'(rr_mdata),  32'h0000_00D0);
    @(posedge clk); #1;
    chk("post_cnt",    32'(rr_cnt),    1);
    chk("post_drain",  32'(rr_mvalid), 0);

    // Fixed priority: ports 1 and 3 always valid with 1-beat packets; port 3 starves.
    do_reset();
    fp_mrdy = 1'b1;
    fp_tvalid = 4'b1010; fp_tlast = 4'b1010; fp_tdata = 32'h3300_1100;
    nfp = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("fp_tready3", 32'(fp_tready[3]), 0);
      if (fp_mvalid) begin
        nfp++;
        chk("fp_tid",  32'(fp_mtid),  1);
        chk("fp_data", 32'(fp_mdata), 32'h11);
      end
    end
    chk("fp_cnt",   32'(fp_cnt), 32'd10);
    chk("fp_beats", 32'(nfp),    32'd10);
    fp_tvalid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
